// File: rtl/puc_pkg.sv
// Shared definitions for the program-counter sequencer and its return stack:
// opcode constants, sequencer state encoding and default widths.
package puc_pkg;

    localparam int DEFAULT_PC_WIDTH     = 8;
    localparam int DEFAULT_OPCODE_WIDTH = 4;

    typedef logic [DEFAULT_OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t NOP   = 4'd0;
    localparam opcode_t JMP   = 4'd1;
    localparam opcode_t JZ    = 4'd2;
    localparam opcode_t CALL  = 4'd3;
    localparam opcode_t RET   = 4'd4;
    localparam opcode_t RESET = 4'd5;
    localparam opcode_t HALT  = 4'd6;

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        FAULT
    } seq_state_t;

endpackage

// File: rtl/my_stack.sv
// Return-address stack driven by pc_sequencer: CALL pushes called_from+1,
// RET pops, RESET empties; return_to shows the current top combinationally.
module MyStack
    import puc_pkg::*;
#(
    parameter int PC_WIDTH     = DEFAULT_PC_WIDTH,
    parameter int OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
    parameter int STACK_DEPTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] stack_code,
    input  logic [PC_WIDTH-1:0]     called_from,
    output logic [PC_WIDTH-1:0]     return_to
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0]       SP_ONE   = DW'(1);
    localparam logic [DW-1:0]       SP_LIMIT = DW'(STACK_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]       sp;
    logic [DW-1:0]       top;

    assign top       = sp - SP_ONE;
    assign return_to = (sp == '0) ? '0 : mem[top[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            sp <= '0;
        end else if (stack_code == OPCODE_WIDTH'(RESET)) begin
            sp <= '0;
        end else if (stack_code == OPCODE_WIDTH'(CALL) && sp < SP_LIMIT) begin
            mem[sp[AW-1:0]] <= called_from + PC_ONE;
            sp              <= sp + SP_ONE;
        end else if (stack_code == OPCODE_WIDTH'(RET) && sp != '0) begin
            sp <= top;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: accepts one decoded instruction per cycle, computes
// the next PC and issues CALL/RET/RESET commands to the return stack.
module pc_sequencer
    import puc_pkg::*;
#(
    parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
    parameter int                  OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
    parameter int                  STACK_DEPTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            instr_valid,
    input  logic [OPCODE_WIDTH-1:0]         instr_opcode,
    input  logic [PC_WIDTH-1:0]             instr_target,
    input  logic                            zero_flag,
    output logic                            instr_ready,
    output logic [PC_WIDTH-1:0]             pc,
    output logic [OPCODE_WIDTH-1:0]         stack_code,
    output logic [PC_WIDTH-1:0]             called_from,
    input  logic [PC_WIDTH-1:0]             return_to,
    output logic [$clog2(STACK_DEPTH):0]    depth,
    output logic                            halted,
    output logic                            fault
);

    localparam int DW = $clog2(STACK_DEPTH) + 1;
    localparam logic [DW-1:0]       DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0]       DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);

    seq_state_t          state, state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [DW-1:0]       depth_next;
    logic                accept;

    assign instr_ready = ~reset & (state == RUN);
    assign accept      = instr_valid & instr_ready;
    assign called_from = pc;
    assign halted      = (state == HALTED);
    assign fault       = (state == FAULT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            depth <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            depth <= depth_next;
        end
    end

    // Depth is tracked locally so a bad CALL/RET never reaches the stack.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        depth_next = depth;
        stack_code = OPCODE_WIDTH'(NOP);
        if (reset) begin
            stack_code = OPCODE_WIDTH'(RESET);
        end else if (accept) begin
            case (instr_opcode)
                OPCODE_WIDTH'(JMP): pc_next = instr_target;
                OPCODE_WIDTH'(JZ):  pc_next = zero_flag ? instr_target : pc + PC_ONE;
                OPCODE_WIDTH'(CALL): begin
                    if (depth < DEPTH_MAX) begin
                        stack_code = OPCODE_WIDTH'(CALL);
                        pc_next    = instr_target;
                        depth_next = depth + DEPTH_ONE;
                    end else begin
                        state_next = FAULT;
                    end
                end
                OPCODE_WIDTH'(RET): begin
                    if (depth != '0) begin
                        stack_code = OPCODE_WIDTH'(RET);
                        pc_next    = return_to;
                        depth_next = depth - DEPTH_ONE;
                    end else begin
                        state_next = FAULT;
                    end
                end
                OPCODE_WIDTH'(RESET): begin
                    stack_code = OPCODE_WIDTH'(RESET);
                    pc_next    = RESET_PC;
                    depth_next = '0;
                end
                OPCODE_WIDTH'(HALT): state_next = HALTED;
                default:             pc_next = pc + PC_ONE;
            endcase
        end
    end

endmodule
